// File: rtl/mod_inv_seq.sv
// rtl/mod_inv_seq.sv - sequential modular inverse d = e^-1 mod phi (extended Euclid, bit-serial div/mul)
// Optional cycle counter output enabled by MOD_INV_CYCLE_CNT_EN.
module mod_inv_seq #(
    parameter int WIDTH   = 128,
    parameter int E_WIDTH = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [E_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]   phi,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   d,
    output logic               err
`ifdef MOD_INV_CYCLE_CNT_EN
    ,
    output logic [31:0]        cycles
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DIV, S_MUL, S_UPD, S_FINAL, S_ERR, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] r_q, r_d, nr_q, nr_d;
    logic [WIDTH:0]   t_q, t_d, nt_q, nt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept, bad_in, last_bit;
    logic [WIDTH:0]   trial, diff, t_fix;

    assign accept   = start && ready;
    assign bad_in   = (phi[WIDTH-1:1] == '0) || (e == '0);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign diff     = trial - {1'b0, nr_q};
    assign t_fix    = t_q + {1'b0, phi_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = bad_in ? S_ERR : S_CHECK;
                else        state_d = S_IDLE;
            end
            S_CHECK: state_d = (nr_q == '0) ? S_FINAL : S_DIV;
            S_DIV:   if (last_bit) state_d = S_MUL;
            S_MUL:   if (last_bit) state_d = S_UPD;
            S_UPD:   state_d = S_CHECK;
            S_FINAL: state_d = (r_q == WIDTH'(1)) ? S_DONE : S_ERR;
            S_ERR:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE) || (state_q == S_DONE);
        done  = (state_q == S_DONE);
    end

    always_comb begin
        r_d     = r_q;
        nr_d    = nr_q;
        t_d     = t_q;
        nt_d    = nt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        phi_d   = phi_q;
        d_d     = d_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && !bad_in) begin
                    phi_d = phi;
                    r_d   = phi;
                    nr_d  = WIDTH'(e);
                    t_d   = '0;
                    nt_d  = (WIDTH+1)'(1);
                end
            end
            S_CHECK: begin
                quo_d = r_q;
                rem_d = '0;
                cnt_d = '0;
            end
            S_DIV: begin
                // Restoring step: dividend bits enter from the top of quo, quotient bits fill the bottom.
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = nt_q;
                end
            end
            S_MUL: begin
                if (quo_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = {mcand_q[WIDTH-1:0], 1'b0};
                quo_d   = {1'b0, quo_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
            end
            S_UPD: begin
                t_d  = nt_q;
                nt_d = t_q - acc_q;
                r_d  = nr_q;
                nr_d = rem_q;
            end
            S_FINAL: begin
                if (r_q == WIDTH'(1)) begin
                    d_d   = t_q[WIDTH] ? t_fix[WIDTH-1:0] : t_q[WIDTH-1:0];
                    err_d = 1'b0;
                end
            end
            S_ERR: begin
                d_d   = '0;
                err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            nr_q    <= '0;
            t_q     <= '0;
            nt_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            phi_q   <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            r_q     <= r_d;
            nr_q    <= nr_d;
            t_q     <= t_d;
            nt_q    <= nt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            phi_q   <= phi_d;
            d_q     <= d_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d   = d_q;
    assign err = err_q;

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Counts the cycle being entered, so the DONE cycle already shows the full latency.
    always_comb begin
        cyc_d = cyc_q;
        if (accept)
            cyc_d = 32'd1;
        else if (state_d != S_IDLE && cyc_q != '1)
            cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mod_inv_seq.sv
// tb/tb_mod_inv_seq.sv - directed self-checking bench for mod_inv_seq (WIDTH=16 and WIDTH=128)
module tb_mod_inv_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         s16 = 1'b0;
    logic [7:0]   e16 = '0;
    logic [15:0]  phi16 = '0;
    logic         rdy16, done16, err16;
    logic [15:0]  d16;

    logic         s128 = 1'b0;
    logic [16:0]  e128 = '0;
    logic [127:0] phi128 = '0;
    logic         rdy128, done128, err128;
    logic [127:0] d128;

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [31:0]  cyc16, cyc128;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_inv_seq #(.WIDTH(16), .E_WIDTH(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .e(e16), .phi(phi16),
        .ready(rdy16), .done(done16), .d(d16), .err(err16)
`ifdef MOD_INV_CYCLE_CNT_EN
        , .cycles(cyc16)
`endif
    );

    mod_inv_seq #(.WIDTH(128), .E_WIDTH(17)) u128 (
        .clk(clk), .rst_n(rst_n), .start(s128), .e(e128), .phi(phi128),
        .ready(rdy128), .done(done128), .d(d128), .err(err128)
`ifdef MOD_INV_CYCLE_CNT_EN
        , .cycles(cyc128)
`endif
    );

    // Called at a negedge with the 16-bit engine ready; returns accept-to-done latency (-1 on timeout).
    task automatic run16(input logic [7:0] ev, input logic [15:0] pv,
                         output int lat, output logic rdy_low);
        s16 = 1'b1; e16 = ev; phi16 = pv;
        @(posedge clk);
        #1 s16 = 1'b0;
        lat = -1;
        rdy_low = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (done16) begin
                lat = n;
                break;
            end
            if (rdy16) rdy_low = 1'b0;
        end
    endtask

    function automatic void model_inv(input logic [127:0] p, input logic [16:0] ev,
                                      output logic [127:0] dv, output int k);
        logic [127:0]        r, nr, q, tmp;
        logic signed [129:0] t, nt, tt;
        r = p; nr = 128'(ev); t = '0; nt = 130'sd1; k = 0;
        while (nr != 0) begin
            q   = r / nr;
            tmp = r - q * nr;
            tt  = t - $signed({2'b00, q}) * nt;
            t   = nt; nt = tt; r = nr; nr = tmp;
            k++;
        end
        if (t < 0) begin
            tt = t + $signed({2'b00, p});
            dv = tt[127:0];
        end else begin
            dv = t[127:0];
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rdy16 !== 1'b1)   begin errors++; $display("FAIL reset_ready16 got=%b exp=1", rdy16); end
        checks++; if (done16 !== 1'b0)  begin errors++; $display("FAIL reset_done16 got=%b exp=0", done16); end
        checks++; if (d16 !== 16'd0)    begin errors++; $display("FAIL reset_d16 got=%0d exp=0", d16); end
        checks++; if (err16 !== 1'b0)   begin errors++; $display("FAIL reset_err16 got=%b exp=0", err16); end
        checks++; if (rdy128 !== 1'b1)  begin errors++; $display("FAIL reset_ready128 got=%b exp=1", rdy128); end
        checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL reset_done128 got=%b exp=0", done128); end
        checks++; if (d128 !== 128'd0)  begin errors++; $display("FAIL reset_d128 got=%0h exp=0", d128); end
        checks++; if (err128 !== 1'b0)  begin errors++; $display("FAIL reset_err128 got=%b exp=0", err128); end
`ifdef MOD_INV_CYCLE_CNT_EN
        checks++; if (cyc16 !== 32'd0)  begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cyc16); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic rl;
        run16(8'd3, 16'd20, lat, rl);
        checks++; if (lat !== 105)   begin errors++; $display("FAIL basic_latency got=%0d exp=105", lat); end
        checks++; if (d16 !== 16'd7) begin errors++; $display("FAIL basic_d got=%0d exp=7", d16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err16); end
        checks++; if (rl !== 1'b1)   begin errors++; $display("FAIL basic_ready_low got=%b exp=1", rl); end
`ifdef MOD_INV_CYCLE_CNT_EN
        checks++; if (cyc16 !== 32'd105) begin errors++; $display("FAIL basic_cycles got=%0d exp=105", cyc16); end
`endif
        repeat (3) @(negedge clk);
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done16); end
        checks++; if (d16 !== 16'd7)   begin errors++; $display("FAIL basic_d_held got=%0d exp=7", d16); end
        checks++; if (rdy16 !== 1'b1)  begin errors++; $display("FAIL basic_ready_idle got=%b exp=1", rdy16); end
    endtask

    task automatic test_back_to_back();
        int lat; logic rl;
        // Each run is accepted in the DONE cycle of the previous one.
        run16(8'd17, 16'd3120, lat, rl);
        checks++; if (lat !== 139)      begin errors++; $display("FAIL b2b_e17_latency got=%0d exp=139", lat); end
        checks++; if (d16 !== 16'd2753) begin errors++; $display("FAIL b2b_e17_d got=%0d exp=2753", d16); end
        checks++; if (err16 !== 1'b0)   begin errors++; $display("FAIL b2b_e17_err got=%b exp=0", err16); end
`ifdef MOD_INV_CYCLE_CNT_EN
        checks++; if (cyc16 !== 32'd139) begin errors++; $display("FAIL b2b_e17_cycles got=%0d exp=139", cyc16); end
`endif
        run16(8'd4, 16'd20, lat, rl);
        checks++; if (lat !== 38)     begin errors++; $display("FAIL gcd4_latency got=%0d exp=38", lat); end
        checks++; if (d16 !== 16'd0)  begin errors++; $display("FAIL gcd4_d got=%0d exp=0", d16); end
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL gcd4_err got=%b exp=1", err16); end
        run16(8'd0, 16'd20, lat, rl);
        checks++; if (lat !== 2)      begin errors++; $display("FAIL e0_latency got=%0d exp=2", lat); end
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL e0_err got=%b exp=1", err16); end
    endtask

    task automatic test_boundary();
        int lat; logic rl;
        run16(8'd3, 16'd1, lat, rl);
        checks++; if (lat !== 2)      begin errors++; $display("FAIL phi1_latency got=%0d exp=2", lat); end
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL phi1_err got=%b exp=1", err16); end
        checks++; if (d16 !== 16'd0)  begin errors++; $display("FAIL phi1_d got=%0d exp=0", d16); end
        run16(8'd23, 16'd20, lat, rl);
        checks++; if (lat !== 173)    begin errors++; $display("FAIL e_gt_phi_latency got=%0d exp=173", lat); end
        checks++; if (d16 !== 16'd7)  begin errors++; $display("FAIL e_gt_phi_d got=%0d exp=7", d16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL e_gt_phi_err got=%b exp=0", err16); end
        run16(8'd20, 16'd20, lat, rl);
        checks++; if (lat !== 38)     begin errors++; $display("FAIL e_eq_phi_latency got=%0d exp=38", lat); end
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL e_eq_phi_err got=%b exp=1", err16); end
        checks++; if (d16 !== 16'd0)  begin errors++; $display("FAIL e_eq_phi_d got=%0d exp=0", d16); end
    endtask

    task automatic test_wide();
        logic [127:0] p, dm;
        logic [255:0] prod;
        int k, lat;
        logic rl;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[127] = 1'b1;
        p[0]   = 1'b0;
        while (p % 128'd65537 == 128'd0) p = p + 128'd2;
        model_inv(p, 17'd65537, dm, k);
        @(negedge clk);
        s128 = 1'b1; e128 = 17'd65537; phi128 = p;
        @(posedge clk);
        #1 s128 = 1'b0;
        lat = -1;
        rl = 1'b1;
        for (int n = 1; n <= 40000; n++) begin
            @(negedge clk);
            if (n == 50) begin
                s128 = 1'b1; e128 = 17'd3; phi128 = 128'd20;
            end else begin
                s128 = 1'b0;
            end
            if (done128) begin
                lat = n;
                break;
            end
            if (rdy128) rl = 1'b0;
        end
        s128 = 1'b0;
        checks++; if (lat !== 3 + k * 258) begin errors++; $display("FAIL wide_latency got=%0d exp=%0d", lat, 3 + k * 258); end
        checks++; if (d128 !== dm)    begin errors++; $display("FAIL wide_d got=%0h exp=%0h", d128, dm); end
        checks++; if (err128 !== 1'b0) begin errors++; $display("FAIL wide_err got=%b exp=0", err128); end
        checks++; if (rl !== 1'b1)    begin errors++; $display("FAIL wide_ready_low got=%b exp=1", rl); end
        prod = 256'(e128 == 17'd65537 ? 17'd65537 : 17'd65537) * 256'(d128);
        prod = prod % 256'(p);
        checks++; if (prod !== 256'd1) begin errors++; $display("FAIL wide_ed_mod_phi got=%0h exp=1", prod); end
        checks++; if (d128 >= p)       begin errors++; $display("FAIL wide_d_range got=%0h exp_below=%0h", d128, p); end
    endtask

    task automatic test_reset_mid();
        int lat, dones;
        logic rl;
        @(negedge clk);
        s16 = 1'b1; e16 = 8'd3; phi16 = 16'd20;
        @(posedge clk);
        #1 s16 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", rdy16); end
        checks++; if (d16 !== 16'd0)  begin errors++; $display("FAIL midrst_d got=%0d exp=0", d16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err16); end
        checks++; if (d128 !== 128'd0) begin errors++; $display("FAIL midrst_d128 got=%0h exp=0", d128); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (done16) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        run16(8'd3, 16'd20, lat, rl);
        checks++; if (lat !== 105)   begin errors++; $display("FAIL postrst_latency got=%0d exp=105", lat); end
        checks++; if (d16 !== 16'd7) begin errors++; $display("FAIL postrst_d got=%0d exp=7", d16); end
`ifdef MOD_INV_CYCLE_CNT_EN
        checks++; if (cyc16 !== 32'(lat)) begin errors++; $display("FAIL postrst_cycles got=%0d exp=%0d", cyc16, lat); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        @(negedge clk);
        test_back_to_back();
        test_boundary();
        test_wide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_inv_seq.md
Name: mod_inv_seq

Overview:
- Parametrised, sequential modular-inverse engine: computes d = e^-1 mod phi using the iterative extended Euclidean algorithm.
- Successor to the combinational private-exponent calculator.
- Sits in the RSA key-setup path between the phi/e source and the key register file.
- Uses a bit-serial divider and a bit-serial multiplier, so area stays small at large WIDTH.
- Reports non-invertible inputs instead of producing garbage.

Parameters:
WIDTH, 128, bit width of phi and d
E_WIDTH, 17, bit width of public exponent e (fits 65537)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
e  in  E_WIDTH  public exponent, sampled on accept
phi  in  WIDTH  modulus, sampled on accept
ready  out  1  engine idle, may accept start
done  out  1  one-cycle pulse, result valid
d  out  WIDTH  inverse in [1, phi-1]; 0 on error; held until next accept
err  out  1  set with done when no inverse exists; held until next accept

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: ready=1, done=0, d=0, err=0; state=IDLE; all datapath registers 0.
- Accept: start=1 while ready=1. Inputs are latched that cycle and ready drops the next cycle.
  - start while ready=0 is ignored (no queueing).
- Internal registers:
  - r, nr: WIDTH bits.
  - t, nt: WIDTH+1 bits, two's complement.
  - q: WIDTH bits.
  - Shift and accumulate registers for the divider and multiplier.
- States:
  - IDLE: wait for accept.
    - phi<2 or e==0 -> ERR.
    - Otherwise load t=0, nt=1, r=phi, nr=zero-extended e -> CHECK.
  - CHECK: nr==0 -> FINAL; else -> DIV.
  - DIV: restoring division r/nr, one quotient bit per cycle, exactly WIDTH cycles. Produces q and rem = r mod nr -> MUL.
  - MUL: shift-add product p = q*nt, one bit of q per cycle, exactly WIDTH cycles.
    - Arithmetic is modulo 2^(WIDTH+1); this is exact because |t| <= phi always.
    - -> UPD.
  - UPD (1 cycle): t<=nt, nt<=t-p, r<=nr, nr<=rem -> CHECK.
  - FINAL (1 cycle):
    - r!=1 -> ERR.
    - Else d <= (t<0 ? t+phi : t) truncated to WIDTH; err<=0 -> DONE.
  - ERR (1 cycle): d<=0, err<=1 -> DONE.
  - DONE (1 cycle): done=1 -> IDLE. ready rises in that same cycle.
- Latency: accept to done = 3 + k*(2*WIDTH+2) cycles, where k is the number of Euclid iterations.
  - k=0 is impossible for valid inputs.
  - Error exits taken from IDLE reach done 2 cycles after accept.
- e>=phi is allowed:
  - If e>phi, the first iteration yields q=0 and swaps the operands; the result equals the inverse of e mod phi.
  - If e==phi, the gcd is phi>=2, so the block reports err.
- Division by zero cannot occur: DIV is entered only when nr!=0.
- rst_n asserted mid-operation:
  - Immediate return to IDLE with the reset values.
  - No done pulse; the partial result is discarded.
- d and err change only in FINAL/ERR. They are stable from the done pulse until the next FINAL/ERR.

Optional Feature:
- Macro: MOD_INV_CYCLE_CNT_EN.
- When defined:
  - Adds output cycles [31:0].
  - Counter cleared on accept, incremented every non-IDLE cycle, saturating at 2^32-1.
  - Value is frozen and valid from done until the next accept.
  - Reset value is 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- WIDTH=16: e=3, phi=20 -> done pulse, d=7, err=0; ready low for the whole run.
- WIDTH=16: e=17, phi=3120 -> d=2753, err=0. Latency matches the formula with the measured k.
- WIDTH=16: e=4, phi=20 (gcd 4) -> d=0, err=1 with done. Then e=0, phi=20 -> err=1 two cycles after accept.
- WIDTH=16: phi=1 -> err=1. Then e=23, phi=20 -> d=7 (e>phi case). Then e=20, phi=20 -> err=1.
- WIDTH=128: e=65537, phi=random even 128-bit with gcd=1 -> d equals the model result and (e*d) mod phi == 1. A start pulse mid-run is ignored.
- Reset mid-DIV: assert rst_n=0 for 1 cycle -> ready=1, d=0, err=0, no done. A new start of e=3, phi=20 -> d=7. With MOD_INV_CYCLE_CNT_EN defined, cycles equals the measured latency.
